// File: rtl/agc_level_controller_if.sv
// Sample-path bus for the AGC: PCM samples in, gain code and level reports back out.
interface agc_level_controller_if #(
  parameter int BITS = 16
);
  logic                   enable;
  logic                   sample_valid;
  logic signed [BITS-1:0] audio_in;
  logic [2:0]             gain_code;
  logic [BITS-1:0]        peak_level;
  logic                   level_valid;
  logic                   clip_flag;

  modport master (
    output enable, sample_valid, audio_in,
    input  gain_code, peak_level, level_valid, clip_flag
  );

  modport slave (
    input  enable, sample_valid, audio_in,
    output gain_code, peak_level, level_valid, clip_flag
  );
endinterface

// File: rtl/agc_level_controller.sv
// Automatic gain controller: windowed peak detector driving a 3-bit gain code,
// with a fast-attack path that backs gain off immediately on full-scale samples.
module agc_level_controller #(
  parameter int         BITS      = 16,
  parameter int         WIN_LOG2  = 10,
  parameter int         HI_THR    = 24576,
  parameter int         LO_THR    = 8192,
  parameter int         HOLD_WIN  = 4,
  parameter logic [2:0] GAIN_MIN  = 3'd1,
  parameter logic [2:0] GAIN_MAX  = 3'd7,
  parameter logic [2:0] GAIN_INIT = 3'd5
) (
  input logic                   clk,
  input logic                   rst_n,
  agc_level_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, HOLD} state_t;

  localparam int                HW         = $clog2(HOLD_WIN + 1);
  localparam logic [BITS-1:0]   FULL_SCALE = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0]   NEG_FULL   = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0]   HI_LEVEL   = BITS'(HI_THR);
  localparam logic [BITS-1:0]   LO_LEVEL   = BITS'(LO_THR);
  localparam logic [BITS-1:0]   MAG_ONE    = BITS'(1);
  localparam logic [WIN_LOG2-1:0] WIN_ONE  = WIN_LOG2'(1);
  localparam logic [HW-1:0]     HOLD_ONE   = HW'(1);
  localparam logic [HW-1:0]     HOLD_LAST  = HW'(HOLD_WIN - 1);

  state_t              state, state_nxt;
  logic [2:0]          gain, gain_nxt;
  logic [WIN_LOG2-1:0] win_cnt, win_nxt;
  logic [BITS-1:0]     acc, acc_nxt;
  logic [HW-1:0]       hold_cnt, hold_nxt;
  logic [BITS-1:0]     peak, peak_nxt;
  logic                level_valid, level_valid_nxt;
  logic                clip, clip_nxt;

  logic [BITS-1:0] sample;
  logic [BITS-1:0] mag;
  logic [BITS-1:0] acc_max;
  logic            win_end;
  logic            clip_hit;

  assign sample = bus.audio_in;

  // The most negative code has no positive twin, so it saturates to full scale.
  always_comb begin
    mag = sample;
    if (sample[BITS-1]) begin
      mag = (sample == NEG_FULL) ? FULL_SCALE : (~sample + MAG_ONE);
    end
  end

  assign acc_max  = (mag > acc) ? mag : acc;
  assign win_end  = bus.sample_valid && (win_cnt == '1);
  assign clip_hit = bus.sample_valid && (mag >= FULL_SCALE) &&
                    ((state == MEASURE) || (state == HOLD));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gain        <= GAIN_INIT;
      win_cnt     <= '0;
      acc         <= '0;
      hold_cnt    <= '0;
      peak        <= '0;
      level_valid <= 1'b0;
      clip        <= 1'b0;
    end else begin
      state       <= state_nxt;
      gain        <= gain_nxt;
      win_cnt     <= win_nxt;
      acc         <= acc_nxt;
      hold_cnt    <= hold_nxt;
      peak        <= peak_nxt;
      level_valid <= level_valid_nxt;
      clip        <= clip_nxt;
    end
  end

  // Priority: disable first, then window/FSM progress, with a clip overriding both.
  always_comb begin
    state_nxt       = state;
    gain_nxt        = gain;
    win_nxt         = win_cnt;
    acc_nxt         = acc;
    hold_nxt        = hold_cnt;
    peak_nxt        = peak;
    level_valid_nxt = 1'b0;
    clip_nxt        = 1'b0;

    if (!bus.enable) begin
      state_nxt = IDLE;
      win_nxt   = '0;
      acc_nxt   = '0;
      hold_nxt  = '0;
    end else begin
      if (bus.sample_valid) begin
        if (win_end) begin
          peak_nxt        = acc_max;
          level_valid_nxt = 1'b1;
          win_nxt         = '0;
          acc_nxt         = '0;
        end else begin
          win_nxt = win_cnt + WIN_ONE;
          acc_nxt = acc_max;
        end
      end

      case (state)
        IDLE: state_nxt = MEASURE;
        MEASURE: begin
          if (win_end) state_nxt = DECIDE;
        end
        DECIDE: begin
          hold_nxt = '0;
          if ((peak >= HI_LEVEL) && (gain > GAIN_MIN)) begin
            gain_nxt  = gain - 3'd1;
            state_nxt = HOLD;
          end else if ((peak < LO_LEVEL) && (gain < GAIN_MAX)) begin
            gain_nxt  = gain + 3'd1;
            state_nxt = HOLD;
          end else begin
            state_nxt = MEASURE;
          end
        end
        HOLD: begin
          if (win_end) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_nxt  = '0;
              state_nxt = MEASURE;
            end else begin
              hold_nxt = hold_cnt + HOLD_ONE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (clip_hit) begin
        clip_nxt = 1'b1;
        if (gain > GAIN_MIN) begin
          gain_nxt  = gain - 3'd1;
          win_nxt   = '0;
          acc_nxt   = '0;
          hold_nxt  = '0;
          state_nxt = HOLD;
        end
      end
    end
  end

  assign bus.gain_code   = gain;
  assign bus.peak_level  = peak;
  assign bus.level_valid = level_valid;
  assign bus.clip_flag   = clip;

endmodule

// File: tb/tb_agc_level_controller.sv
// Bench for agc_level_controller: directed scenarios plus random traffic, all
// checked every cycle against a window/hold-count reference model.
module tb_agc_level_controller;

  localparam int WIN  = 16;
  localparam int HOLD = 2;
  localparam int HI   = 24576;
  localparam int LO   = 8192;
  localparam int FS   = 32767;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  agc_level_controller_if #(.BITS(16)) bus ();

  agc_level_controller #(
    .BITS(16), .WIN_LOG2(4), .HI_THR(HI), .LO_THR(LO), .HOLD_WIN(HOLD),
    .GAIN_MIN(3'd1), .GAIN_MAX(3'd7), .GAIN_INIT(3'd5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_gain, m_peak, m_cnt, m_acc, m_hold_left;
  bit m_lv, m_clip, m_decide, m_running;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: counts valid samples per window, tracks windows left to wait
  // after a gain change, and flags a pending decision one cycle after a window.
  task automatic modelStep(input bit en, input bit vld, input int s);
    int mag;
    bit endw, was_running, was_decide;
    if (!rst_n) begin
      m_gain = 5; m_peak = 0; m_lv = 0; m_clip = 0; m_cnt = 0; m_acc = 0;
      m_hold_left = 0; m_decide = 0; m_running = 0;
      return;
    end
    m_lv = 0;
    m_clip = 0;
    if (!en) begin
      m_running = 0; m_decide = 0; m_hold_left = 0; m_cnt = 0; m_acc = 0;
      return;
    end
    mag = (s < 0) ? -s : s;
    if (mag > FS) mag = FS;
    was_running = m_running;
    was_decide  = m_decide;
    m_decide    = 0;
    m_running   = 1;
    endw        = 0;
    if (was_decide) begin
      if (m_peak >= HI && m_gain > 1) begin
        m_gain--; m_hold_left = HOLD;
      end else if (m_peak < LO && m_gain < 7) begin
        m_gain++; m_hold_left = HOLD;
      end
    end
    if (vld) begin
      if (mag > m_acc) m_acc = mag;
      m_cnt++;
      if (m_cnt == WIN) begin
        m_peak = m_acc; m_lv = 1; m_cnt = 0; m_acc = 0; endw = 1;
      end
    end
    if (was_running && !was_decide && endw) begin
      if (m_hold_left > 0) m_hold_left--;
      else m_decide = 1;
    end
    if (was_running && !was_decide && vld && mag >= FS) begin
      m_clip = 1;
      if (m_gain > 1) begin
        m_gain--; m_cnt = 0; m_acc = 0; m_hold_left = HOLD; m_decide = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit en, input bit vld, input int s);
    bus.enable       = en;
    bus.sample_valid = vld;
    bus.audio_in     = 16'(s);
    @(posedge clk);
    modelStep(en, vld, s);
    #1;
    checkOutput("gain", 32'(bus.gain_code), m_gain);
    checkOutput("peak", 32'(bus.peak_level), m_peak);
    checkOutput("level_valid", 32'(bus.level_valid), 32'(m_lv));
    checkOutput("clip_flag", 32'(bus.clip_flag), 32'(m_clip));
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    repeat (n) applyStimulus(1'b1, 1'b0, 0);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 0);
  endtask

  task automatic runWindow(input int amp, input bit gappy);
    for (int i = 0; i < WIN; i++) begin
      if (gappy) applyStimulus(1'b1, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, (i % 2 == 1) ? -amp : amp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_gain"}, 32'(bus.gain_code), 5);
    checkOutput({tag, "_peak"}, 32'(bus.peak_level), 0);
    checkOutput({tag, "_lv"}, 32'(bus.level_valid), 0);
    checkOutput({tag, "_clip"}, 32'(bus.clip_flag), 0);
  endtask

  initial begin
    int cls, amp, s;
    bit en, vld;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.sample_valid = 1'b0;
    bus.audio_in = '0;

    doReset(2);
    checkResetValues("reset");

    // Loud windows: decrease, two held windows, then decrease again.
    runWindow(26000, 1'b0);
    checkOutput("loud_peak", 32'(bus.peak_level), 26000);
    checkOutput("loud_lv", 32'(bus.level_valid), 1);
    idle(2);
    checkOutput("loud_gain1", 32'(bus.gain_code), 4);
    runWindow(26000, 1'b0);
    runWindow(26000, 1'b0);
    idle(2);
    checkOutput("loud_held", 32'(bus.gain_code), 4);
    runWindow(26000, 1'b0);
    idle(2);
    checkOutput("loud_gain2", 32'(bus.gain_code), 3);

    // Quiet with gaps: increase, then saturate at 7.
    doReset(2);
    runWindow(1000, 1'b1);
    checkOutput("quiet_peak", 32'(bus.peak_level), 1000);
    idle(2);
    checkOutput("quiet_gain", 32'(bus.gain_code), 6);
    repeat (12) runWindow(1000, 1'b1);
    idle(2);
    checkOutput("quiet_sat", 32'(bus.gain_code), 7);

    // Fast attack mid-window, window restart, then clipping down to the floor.
    doReset(2);
    repeat (7) applyStimulus(1'b1, 1'b1, 5000);
    applyStimulus(1'b1, 1'b1, -32768);
    checkOutput("fa_clip", 32'(bus.clip_flag), 1);
    checkOutput("fa_gain", 32'(bus.gain_code), 4);
    repeat (15) applyStimulus(1'b1, 1'b1, 5000);
    checkOutput("fa_no_lv", 32'(bus.level_valid), 0);
    applyStimulus(1'b1, 1'b1, 5000);
    checkOutput("fa_lv", 32'(bus.level_valid), 1);
    repeat (3) applyStimulus(1'b1, 1'b1, FS);
    applyStimulus(1'b1, 1'b1, -FS);
    checkOutput("fa_min_clip", 32'(bus.clip_flag), 1);
    checkOutput("fa_min_gain", 32'(bus.gain_code), 1);

    // Threshold edges and window-end maximum.
    doReset(2);
    runWindow(8192, 1'b0);
    idle(2);
    checkOutput("edge_lo", 32'(bus.gain_code), 5);
    runWindow(24575, 1'b0);
    idle(2);
    checkOutput("edge_hi", 32'(bus.gain_code), 5);
    repeat (15) applyStimulus(1'b1, 1'b1, 10000);
    applyStimulus(1'b1, 1'b1, -24576);
    checkOutput("last_max_peak", 32'(bus.peak_level), 24576);
    idle(2);
    checkOutput("edge_thr_gain", 32'(bus.gain_code), 4);

    // Enable drop mid-window, re-enable, then reset mid-hold.
    doReset(2);
    repeat (8) applyStimulus(1'b1, 1'b1, 26000);
    repeat (3) applyStimulus(1'b0, 1'b1, 26000);
    repeat (8) applyStimulus(1'b1, 1'b1, 26000);
    checkOutput("reen_no_lv", 32'(bus.level_valid), 0);
    repeat (8) applyStimulus(1'b1, 1'b1, 26000);
    idle(2);
    checkOutput("reen_gain", 32'(bus.gain_code), 4);
    runWindow(26000, 1'b0);
    doReset(1);
    checkResetValues("hold_reset");

    // Random traffic in segments so sustained loud/quiet periods occur.
    doReset(2);
    cls = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) cls = $urandom_range(0, 3);
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      en  = ($urandom_range(0, 99) < 97);
      vld = ($urandom_range(0, 2) != 0);
      case (cls)
        0: amp = $urandom_range(0, 8191);
        1: amp = $urandom_range(8192, 24575);
        2: amp = $urandom_range(24576, 32767);
        default: amp = ($urandom_range(0, 19) == 0) ? 32768 : $urandom_range(0, 30000);
      endcase
      s = $urandom_range(0, 1) ? -amp : amp;
      if (s > FS) s = FS;
      applyStimulus(en, vld, s);
      checkOutput("gain_range", 32'((bus.gain_code >= 3'd1) && (bus.gain_code <= 3'd7)), 1);
      rst_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
